traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
- Sequences a two-direction traffic intersection (north-south / east-west) from a 1 Hz tick.
- Produces a per-direction seconds-remaining count.
- Time-shares one external combinational 8-bit binary-to-BCD converter between the two counts, holding each 2-digit BCD result in a register for the 7-segment display drivers.
- Sits between the board clock and the display/light output stage.

Parameters:
- CLK_FREQ, 12000000: input clock cycles per 1 Hz tick.
- T_GREEN, 30: green duration in seconds, 1..99.
- T_YELLOW, 3: yellow duration in seconds, 1..99.
- T_ALLRED, 2: all-red clearance in seconds, 1..99.
- Constraint: T_GREEN+T_YELLOW+2*T_ALLRED <= 99. Violation is a static assertion (elaboration error).

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = freeze prescaler, phase counter and FSM.
- flash_mode  in  1  1 = request yellow-flash (fault/night) mode.
- bcd_in  in  8  result from the shared converter, {tens, ones}.
- bin_out  out  8  operand to the shared converter. Combinational: sel ? ew_cnt : ns_cnt.
- ns_light  out  3  {R,Y,G}, one-hot or all-off.
- ew_light  out  3  {R,Y,G}.
- ns_bcd  out  8  registered NS remaining seconds, BCD.
- ew_bcd  out  8  registered EW remaining seconds, BCD.
- tick  out  1  one-cycle 1 Hz strobe, for display blink logic.

Behaviour:
- Reset values: state NS_GREEN, phase_cnt = T_GREEN, prescaler 0, tick 0, sel 0, ns_light 001, ew_light 100, ns_bcd 8'h00, ew_bcd 8'h00, flash_on 0.
- Prescaler: counts 0..CLK_FREQ-1 while enable=1. tick=1 for the single cycle at terminal count, then wraps to 0. enable=0 holds the count; no tick is issued.
- Phase counter: loaded with the duration on entry to each state. Decrements on tick. When tick && phase_cnt==1, the FSM advances and phase_cnt loads the next duration, so the display reads T..1 and never 0 in normal states.
- FSM sequence: NS_GREEN(T_GREEN) -> NS_YELLOW(T_YELLOW) -> ALL_RED1(T_ALLRED) -> EW_GREEN(T_GREEN) -> EW_YELLOW(T_YELLOW) -> ALL_RED2(T_ALLRED) -> NS_GREEN.
- Lights per state:
  - NS_GREEN: ns 001, ew 100.
  - NS_YELLOW: ns 010, ew 100.
  - ALL_RED*: both 100.
  - EW states: mirror of the NS states.
- Counts (8-bit, unsigned, combinational from state and phase_cnt):
  - NS_GREEN: ns = p; ew = p + T_YELLOW + T_ALLRED.
  - NS_YELLOW: ns = p; ew = p + T_ALLRED.
  - ALL_RED1: ns = p + T_GREEN + T_YELLOW + T_ALLRED; ew = p.
  - EW_GREEN, EW_YELLOW, ALL_RED2: symmetric, with ns and ew swapped.
  - FLASH: both counts are 0.
- FLASH mode:
  - Any state with flash_mode=1 enters FLASH on the next clock edge, regardless of tick or enable.
  - In FLASH: flash_on toggles on each tick; both lights = flash_on ? 010 : 000.
  - When flash_mode falls: enter ALL_RED2 with phase_cnt = T_ALLRED, then NS_GREEN normally.
  - flash_mode and the phase terminal count in the same cycle: FLASH wins.
- Converter sharing:
  - sel toggles every clock, unconditionally, including while enable=0.
  - On an edge with sel=0: ns_bcd <= bcd_in. On an edge with sel=1: ew_bcd <= bcd_in.
  - Each BCD output reflects its count within 2 clocks of any count change.
- Reset mid-operation: all registers return to reset values immediately on rst_n low. No partial phase is preserved.

Decomposition:
- Shared package traffic_pkg:
  - state encoding (7 states);
  - light constants L_RED=3'b100, L_YEL=3'b010, L_GRN=3'b001, L_OFF=3'b000.
- Sub-module tick_gen (prescaler plus enable gating, parameter CLK_FREQ, output tick).
- The converter stays external and is instantiated by the parent alongside this block.

Test Plan:
- Setup: CLK_FREQ=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, bench converter model in loop.
- Reset: release rst_n -> ns_light=001, ew_light=100; within 2 clks ns_bcd=8'h05, ew_bcd=8'h08; first tick 4 clks after release.
- Full cycle: 5 ticks -> NS_YELLOW, ns_bcd=02, ew_bcd=03. 2 ticks -> ALL_RED1, ns_bcd=09, ew_bcd=01. 1 tick -> EW_GREEN, ew_bcd=05, ns_bcd=08. Back to NS_GREEN after 16 ticks = 64 clks.
- Pause: in NS_GREEN with ns_bcd=03, drop enable for 20 clks -> no tick, lights and BCD constant, sel still toggling. Re-enable -> ns_bcd=02 after 4 clks.
- Flash: assert flash_mode in EW_GREEN -> next clk both lights 000, then 010/000 alternating per tick, BCD 00/00. Deassert -> ALL_RED2 for 1 tick (both 100), then NS_GREEN with ns_bcd=05.
- Sharing: check bin_out = ns_cnt when sel=0 and ew_cnt when sel=1. Drive bcd_in=8'h42 on a sel=1 edge only -> ew_bcd=42, ns_bcd unchanged.
- Async reset: pulse rst_n low mid-EW_YELLOW, between clock edges -> outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the intersection phase controller.
// Lights are {R,Y,G}; lights_for maps a state to the {ns,ew} light pair.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  function automatic logic [5:0] lights_for(state_t s, logic flash_on);
    case (s)
      NS_GREEN:  return {L_GRN, L_RED};
      NS_YELLOW: return {L_YEL, L_RED};
      EW_GREEN:  return {L_RED, L_GRN};
      EW_YELLOW: return {L_RED, L_YEL};
      FLASH:     return flash_on ? {L_YEL, L_YEL} : {L_OFF, L_OFF};
      default:   return {L_RED, L_RED};
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a registered one-cycle strobe every CLK_FREQ cycles.
// enable=0 holds the count and suppresses the strobe.
module tick_gen #(
  parameter int CLK_FREQ = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == TERM) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-direction intersection sequencer with per-direction countdowns,
// time-sharing one external binary-to-BCD converter between the two counts.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       flash_mode,
  input  logic [7:0] bcd_in,
  output logic [7:0] bin_out,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] ns_bcd,
  output logic [7:0] ew_bcd,
  output logic       tick
);

  if (T_GREEN < 1 || T_GREEN > 99 || T_YELLOW < 1 || T_YELLOW > 99 ||
      T_ALLRED < 1 || T_ALLRED > 99 ||
      T_GREEN + T_YELLOW + 2 * T_ALLRED > 99) begin : g_bad_timing
    $error("traffic_phase_ctrl: phase durations out of range");
  end

  localparam logic [7:0] TG = 8'(T_GREEN);
  localparam logic [7:0] TY = 8'(T_YELLOW);
  localparam logic [7:0] TA = 8'(T_ALLRED);

  state_t     state_q, state_d, next_normal;
  logic [7:0] phase_q, phase_d, dur_next;
  logic       flash_on_q, flash_on_d;
  logic       sel_q;
  logic [2:0] ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic [7:0] ns_bcd_q, ns_bcd_d, ew_bcd_q, ew_bcd_d;
  logic [7:0] ns_cnt, ew_cnt;
  logic       step;

  tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign step = tick & enable;

  always_comb begin
    case (state_q)
      NS_GREEN:  next_normal = NS_YELLOW;
      NS_YELLOW: next_normal = ALL_RED1;
      ALL_RED1:  next_normal = EW_GREEN;
      EW_GREEN:  next_normal = EW_YELLOW;
      EW_YELLOW: next_normal = ALL_RED2;
      default:   next_normal = NS_GREEN;
    endcase
    case (next_normal)
      NS_YELLOW, EW_YELLOW: dur_next = TY;
      ALL_RED1, ALL_RED2:   dur_next = TA;
      default:              dur_next = TG;
    endcase
  end

  // Flash requests override everything, including a same-cycle terminal count.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    flash_on_d = flash_on_q;
    if (flash_mode) begin
      state_d = FLASH;
      if (state_q != FLASH) flash_on_d = 1'b0;
      else if (step)        flash_on_d = ~flash_on_q;
    end else if (state_q == FLASH) begin
      state_d    = ALL_RED2;
      phase_d    = TA;
      flash_on_d = 1'b0;
    end else if (step) begin
      if (phase_q == 8'd1) begin
        state_d = next_normal;
        phase_d = dur_next;
      end else begin
        phase_d = phase_q - 8'd1;
      end
    end
    {ns_light_d, ew_light_d} = lights_for(state_d, flash_on_d);
  end

  always_comb begin
    ns_cnt = 8'd0;
    ew_cnt = 8'd0;
    case (state_q)
      NS_GREEN:  begin ns_cnt = phase_q;                ew_cnt = phase_q + TY + TA;      end
      NS_YELLOW: begin ns_cnt = phase_q;                ew_cnt = phase_q + TA;           end
      ALL_RED1:  begin ns_cnt = phase_q + TG + TY + TA; ew_cnt = phase_q;                end
      EW_GREEN:  begin ew_cnt = phase_q;                ns_cnt = phase_q + TY + TA;      end
      EW_YELLOW: begin ew_cnt = phase_q;                ns_cnt = phase_q + TA;           end
      ALL_RED2:  begin ew_cnt = phase_q + TG + TY + TA; ns_cnt = phase_q;                end
      default:   begin ns_cnt = 8'd0;                   ew_cnt = 8'd0;                   end
    endcase
  end

  assign bin_out  = sel_q ? ew_cnt : ns_cnt;
  assign ns_bcd_d = sel_q ? ns_bcd_q : bcd_in;
  assign ew_bcd_d = sel_q ? bcd_in : ew_bcd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NS_GREEN;
      phase_q    <= TG;
      flash_on_q <= 1'b0;
      sel_q      <= 1'b0;
      ns_light_q <= L_GRN;
      ew_light_q <= L_RED;
      ns_bcd_q   <= 8'h00;
      ew_bcd_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      flash_on_q <= flash_on_d;
      sel_q      <= ~sel_q;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      ns_bcd_q   <= ns_bcd_d;
      ew_bcd_q   <= ew_bcd_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign ns_bcd   = ns_bcd_q;
  assign ew_bcd   = ew_bcd_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: stimulus queues the expected lights/BCD after each tick,
// a tick-driven monitor pops and compares once the BCD registers settle.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int CF = 4;

  logic       clk = 1'b0;
  logic       rst_n, enable, flash_mode, override;
  logic [7:0] bcd_in, bin_out, ns_bcd, ew_bcd;
  logic [2:0] ns_light, ew_light;
  logic       tick;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .CLK_FREQ(CF), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flash_mode (flash_mode),
    .bcd_in     (bcd_in),
    .bin_out    (bin_out),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ns_bcd     (ns_bcd),
    .ew_bcd     (ew_bcd),
    .tick       (tick)
  );

  // Behavioural stand-in for the shared external converter.
  always_comb begin
    bcd_in = {4'(bin_out / 8'd10), 4'(bin_out % 8'd10)};
    if (override) bcd_in = 8'h42;
  end

  typedef struct {
    string      name;
    logic [2:0] nl;
    logic [2:0] el;
    logic [7:0] nb;
    logic [7:0] eb;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(string n, logic [2:0] nl, logic [2:0] el, logic [7:0] nb, logic [7:0] eb);
    exp_t e;
    e.name = n; e.nl = nl; e.el = el; e.nb = nb; e.eb = eb;
    return e;
  endfunction

  // State after the k-th tick of a cycle starting in NS_GREEN with 5 s left.
  function automatic exp_t cyc(int k);
    case (k)
      1:  return mk("t1_nsg",  L_GRN, L_RED, 8'h04, 8'h07);
      2:  return mk("t2_nsg",  L_GRN, L_RED, 8'h03, 8'h06);
      3:  return mk("t3_nsg",  L_GRN, L_RED, 8'h02, 8'h05);
      4:  return mk("t4_nsg",  L_GRN, L_RED, 8'h01, 8'h04);
      5:  return mk("t5_nsy",  L_YEL, L_RED, 8'h02, 8'h03);
      6:  return mk("t6_nsy",  L_YEL, L_RED, 8'h01, 8'h02);
      7:  return mk("t7_ar1",  L_RED, L_RED, 8'h09, 8'h01);
      8:  return mk("t8_ewg",  L_RED, L_GRN, 8'h08, 8'h05);
      9:  return mk("t9_ewg",  L_RED, L_GRN, 8'h07, 8'h04);
      10: return mk("t10_ewg", L_RED, L_GRN, 8'h06, 8'h03);
      11: return mk("t11_ewg", L_RED, L_GRN, 8'h05, 8'h02);
      12: return mk("t12_ewg", L_RED, L_GRN, 8'h04, 8'h01);
      13: return mk("t13_ewy", L_RED, L_YEL, 8'h03, 8'h02);
      14: return mk("t14_ewy", L_RED, L_YEL, 8'h02, 8'h01);
      15: return mk("t15_ar2", L_RED, L_RED, 8'h01, 8'h09);
      default: return mk("t16_nsg", L_GRN, L_RED, 8'h05, 8'h08);
    endcase
  endfunction

  task automatic push_cycle(input int from, input int to);
    for (int k = from; k <= to; k++) exp_q.push_back(cyc(k));
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (tick !== 1'b1 && guard < 4 * CF + 4);
      if (tick !== 1'b1) begin
        check_output("tick_timeout", 32'(tick), 32'd1);
        return;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_tick", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          repeat (3) @(negedge clk);
          check_output({e.name, "_ns_light"}, 32'(ns_light), 32'(e.nl));
          check_output({e.name, "_ew_light"}, 32'(ew_light), 32'(e.el));
          check_output({e.name, "_ns_bcd"},   32'(ns_bcd),   32'(e.nb));
          check_output({e.name, "_ew_bcd"},   32'(ew_bcd),   32'(e.eb));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : apply_stimulus
    int first_tick, bad_stable, bad_sel, g;
    logic [7:0] prev, a, b;

    rst_n = 1'b0; enable = 1'b1; flash_mode = 1'b0; override = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_ns_light", 32'(ns_light), 32'(L_GRN));
    check_output("rst_ew_light", 32'(ew_light), 32'(L_RED));
    check_output("rst_ns_bcd",   32'(ns_bcd),   32'h00);
    check_output("rst_ew_bcd",   32'(ew_bcd),   32'h00);
    check_output("rst_tick",     32'(tick),     32'd0);

    // Full cycle back to NS_GREEN.
    mon_en = 1'b1;
    push_cycle(1, 16);
    rst_n = 1'b1;
    first_tick = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        check_output("rel_ns_bcd", 32'(ns_bcd), 32'h05);
        check_output("rel_ew_bcd", 32'(ew_bcd), 32'h08);
      end
      if (tick === 1'b1) begin
        first_tick = i;
        break;
      end
    end
    check_output("first_tick_clks", 32'(first_tick), 32'd4);
    wait_ticks(16);
    repeat (3) @(negedge clk);

    // Pause with ns=3.
    push_cycle(1, 2);
    wait_ticks(2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    bad_stable = 0; bad_sel = 0; prev = bin_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || ns_light !== L_GRN || ew_light !== L_RED ||
          ns_bcd !== 8'h03 || ew_bcd !== 8'h06) bad_stable++;
      if (bin_out === prev) bad_sel++;
      prev = bin_out;
    end
    check_output("pause_stable",     32'(bad_stable), 32'd0);
    check_output("pause_sel_toggle", 32'(bad_sel),    32'd0);
    push_cycle(3, 3);
    enable = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_output("resume_ns_bcd", 32'(ns_bcd), 32'h02);

    // Flash entry from EW_GREEN.
    push_cycle(4, 8);
    wait_ticks(5);
    repeat (3) @(negedge clk);
    exp_q.push_back(mk("flash1", L_YEL, L_YEL, 8'h00, 8'h00));
    exp_q.push_back(mk("flash2", L_OFF, L_OFF, 8'h00, 8'h00));
    flash_mode = 1'b1;
    @(posedge clk); #1;
    check_output("flash_entry_ns", 32'(ns_light), 32'(L_OFF));
    check_output("flash_entry_ew", 32'(ew_light), 32'(L_OFF));
    wait_ticks(2);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    wait_ticks(1);
    @(negedge clk);
    check_output("flash3_ns", 32'(ns_light), 32'(L_YEL));
    check_output("flash3_ew", 32'(ew_light), 32'(L_YEL));
    flash_mode = 1'b0;
    @(posedge clk); #1;
    check_output("ar2_ns_light", 32'(ns_light), 32'(L_RED));
    check_output("ar2_ew_light", 32'(ew_light), 32'(L_RED));
    exp_q.push_back(mk("post_flash_nsg", L_GRN, L_RED, 8'h05, 8'h08));
    mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_output("ar2_ns_bcd", 32'(ns_bcd), 32'h01);
    check_output("ar2_ew_bcd", 32'(ew_bcd), 32'h09);
    wait_ticks(1);
    repeat (3) @(negedge clk);

    // Converter sharing, frozen in NS_GREEN with ns=5, ew=8.
    enable = 1'b0;
    a = bin_out;
    @(negedge clk);
    b = bin_out;
    check_output("bin_out_alternates",
                 32'((a == 8'd5 && b == 8'd8) || (a == 8'd8 && b == 8'd5)), 32'd1);
    g = 0;
    while (bin_out !== 8'd8 && g < 3) begin
      @(negedge clk);
      g++;
    end
    override = 1'b1;
    @(posedge clk); #1;
    override = 1'b0;
    check_output("share_ew_bcd", 32'(ew_bcd), 32'h42);
    check_output("share_ns_bcd", 32'(ns_bcd), 32'h05);
    repeat (2) @(posedge clk); #1;
    check_output("share_ew_restore", 32'(ew_bcd), 32'h08);

    // Run into EW_YELLOW, then reset between edges.
    @(negedge clk);
    enable = 1'b1;
    push_cycle(1, 13);
    wait_ticks(13);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_ns_light", 32'(ns_light), 32'(L_GRN));
    check_output("arst_ew_light", 32'(ew_light), 32'(L_RED));
    check_output("arst_ns_bcd",   32'(ns_bcd),   32'h00);
    check_output("arst_ew_bcd",   32'(ew_bcd),   32'h00);
    check_output("arst_tick",     32'(tick),     32'd0);
    check_output("arst_bin_out",  32'(bin_out),  32'h05);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_output("rerel_ns_bcd", 32'(ns_bcd), 32'h05);
    check_output("rerel_ew_bcd", 32'(ew_bcd), 32'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
